// File: rtl/tdm_pkg.sv
// Shared TDM definitions used by both the receive demux and the transmit sequencer.
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_e;

  // Width of a slot index for an n-slot frame (never narrower than one bit).
  function automatic int tdm_slot_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Mod-N slot counter with increment, load-to-1 and clear controls.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter  int N  = 5,
  localparam int SW = tdm_slot_w(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          load1,
  input  logic          clr,
  output logic [SW-1:0] slot,
  output logic          last
);

  logic [SW-1:0] slot_q;
  logic [SW-1:0] slot_d;

  assign last = (slot_q == SW'(N - 1));
  assign slot = slot_q;

  // Next slot: clear wins over load, load wins over increment; increment wraps at N-1.
  always_comb begin
    slot_d = slot_q;
    if (clr) begin
      slot_d = '0;
    end else if (load1) begin
      slot_d = SW'(1);
    end else if (inc) begin
      slot_d = last ? '0 : slot_q + SW'(1);
    end
  end

  // Slot register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/tdm_demux_1xn.sv
// Receive-side 1:N TDM demultiplexer: serial slots in, parallel frame out with a valid pulse.
module tdm_demux_1xn
  import tdm_pkg::*;
#(
  parameter  int NUM_OF_OUTPUTS = 5,
  localparam int SW             = tdm_slot_w(NUM_OF_OUTPUTS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      d,
  input  logic                      d_valid,
  input  logic                      frame_start,
  output logic [NUM_OF_OUTPUTS-1:0] f,
  output logic                      f_valid,
  output logic [SW-1:0]             slot,
  output logic                      locked,
  output logic                      sync_err
);

  localparam int N = NUM_OF_OUTPUTS;

  tdm_state_e    state_q, state_d;
  logic [N-1:0]  shadow_q, shadow_d;
  logic [N-1:0]  f_q, f_d;
  logic          f_valid_q, f_valid_d;
  logic          sync_err_q, sync_err_d;

  logic          cnt_inc;
  logic          cnt_load1;
  logic          cnt_clr;
  logic [SW-1:0] slot_q;
  logic          slot_last;

  tdm_slot_counter #(
    .N (N)
  ) u_slot_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (cnt_inc),
    .load1 (cnt_load1),
    .clr   (cnt_clr),
    .slot  (slot_q),
    .last  (slot_last)
  );

  // Framing FSM: decides where each accepted beat goes and when a frame or error is reported.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    f_d        = f_q;
    f_valid_d  = 1'b0;
    sync_err_d = 1'b0;
    cnt_inc    = 1'b0;
    cnt_load1  = 1'b0;
    cnt_clr    = 1'b0;

    if (d_valid) begin
      case (state_q)
        HUNT: begin
          // Anything before the first marker is line noise and is dropped silently.
          if (frame_start) begin
            shadow_d[0] = d;
            cnt_load1   = 1'b1;
            state_d     = LOCKED;
          end
        end

        LOCKED: begin
          if (frame_start) begin
            // A marker mid-frame restarts the frame on this beat; the partial frame is dropped.
            if (slot_q != '0) begin
              sync_err_d = 1'b1;
            end
            shadow_d[0] = d;
            cnt_load1   = 1'b1;
          end else if (slot_q == '0) begin
            // Missing marker where one was due: framing lost, go back to hunting.
            sync_err_d = 1'b1;
            cnt_clr    = 1'b1;
            state_d    = HUNT;
          end else if (slot_last) begin
            // Final slot goes straight to the output so the frame completes on this edge.
            f_d        = shadow_q;
            f_d[N-1]   = d;
            f_valid_d  = 1'b1;
            cnt_clr    = 1'b1;
          end else begin
            shadow_d[slot_q] = d;
            cnt_inc          = 1'b1;
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  // State, shadow and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HUNT;
      shadow_q   <= '0;
      f_q        <= '0;
      f_valid_q  <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      f_q        <= f_d;
      f_valid_q  <= f_valid_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign f        = f_q;
  assign f_valid  = f_valid_q;
  assign sync_err = sync_err_q;
  assign slot     = slot_q;
  assign locked   = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux_1xn.sv
// Testbench for tdm_demux_1xn: three instances (N=5, 2, 8) checked against a slot-position model.
module tb_tdm_demux_1xn;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: N=5
  logic       d5 = 0, dv5 = 0, fs5 = 0;
  logic [4:0] f5;
  logic       fv5, lk5, se5;
  logic [2:0] sl5;
  // Instance 1: N=2
  logic       d2 = 0, dv2 = 0, fs2 = 0;
  logic [1:0] f2;
  logic       fv2, lk2, se2;
  logic [0:0] sl2;
  // Instance 2: N=8
  logic       d8 = 0, dv8 = 0, fs8 = 0;
  logic [7:0] f8;
  logic       fv8, lk8, se8;
  logic [2:0] sl8;

  tdm_demux_1xn #(.NUM_OF_OUTPUTS(5)) u5 (
    .clk(clk), .reset(reset), .d(d5), .d_valid(dv5), .frame_start(fs5),
    .f(f5), .f_valid(fv5), .slot(sl5), .locked(lk5), .sync_err(se5));
  tdm_demux_1xn #(.NUM_OF_OUTPUTS(2)) u2 (
    .clk(clk), .reset(reset), .d(d2), .d_valid(dv2), .frame_start(fs2),
    .f(f2), .f_valid(fv2), .slot(sl2), .locked(lk2), .sync_err(se2));
  tdm_demux_1xn #(.NUM_OF_OUTPUTS(8)) u8 (
    .clk(clk), .reset(reset), .d(d8), .d_valid(dv8), .frame_start(fs8),
    .f(f8), .f_valid(fv8), .slot(sl8), .locked(lk8), .sync_err(se8));

  int checks = 0;
  int errors = 0;

  // Expected output events per instance: bit 8 = sync_err, bits 7:0 = completed frame.
  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];
  logic [8:0] exp_q2[$];

  int         nn[3]     = '{5, 2, 8};
  int         pos[3]    = '{-1, -1, -1};   // -1: no frame alignment known
  logic [7:0] mbits[3];
  bit         cont[3]   = '{0, 0, 0};      // continuous-stream phase: check f_valid cadence
  int         last_fv[3] = '{-1, -1, -1};
  int         cyc = 0;

  bit nv[3], nd[3], nf[3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int w, input logic [8:0] item);
    case (w)
      0: exp_q0.push_back(item);
      1: exp_q1.push_back(item);
      default: exp_q2.push_back(item);
    endcase
  endtask

  // Reference: track the position inside the current frame as a plain integer.
  task automatic model(input int w, input bit d, input bit fs);
    if (pos[w] < 0) begin
      if (fs) begin
        mbits[w] = '0; mbits[w][0] = d; pos[w] = 1;
      end
    end else if (fs) begin
      if (pos[w] != 0) push(w, 9'h100);
      mbits[w] = '0; mbits[w][0] = d; pos[w] = 1;
    end else if (pos[w] == 0) begin
      push(w, 9'h100);
      pos[w] = -1;
    end else begin
      mbits[w][pos[w]] = d;
      pos[w]++;
      if (pos[w] == nn[w]) begin
        push(w, {1'b0, mbits[w]});
        pos[w] = 0;
      end
    end
  endtask

  task automatic beat(input int w, input bit d, input bit fs);
    nv[w] = 1; nd[w] = d; nf[w] = fs;
  endtask

  // Apply the beats queued for this cycle just after a rising edge; unqueued instances idle.
  task automatic step();
    @(posedge clk);
    #1;
    dv5 = nv[0]; d5 = nd[0]; fs5 = nf[0];
    dv2 = nv[1]; d2 = nd[1]; fs2 = nf[1];
    dv8 = nv[2]; d8 = nd[2]; fs8 = nf[2];
    for (int w = 0; w < 3; w++) begin
      if (nv[w]) model(w, nd[w], nf[w]);
      nv[w] = 0; nd[w] = 0; nf[w] = 0;
    end
  endtask

  task automatic mon(input int w, input logic fv, input logic se, input logic [7:0] fval);
    logic [8:0] item;
    bit empty;
    if (fv || se) begin
      empty = 0;
      case (w)
        0: if (exp_q0.size() == 0) empty = 1; else item = exp_q0.pop_front();
        1: if (exp_q1.size() == 0) empty = 1; else item = exp_q1.pop_front();
        default: if (exp_q2.size() == 0) empty = 1; else item = exp_q2.pop_front();
      endcase
      checks++;
      if (empty) begin
        errors++;
        $display("FAIL unexpected_out inst%0d: f_valid=%0b sync_err=%0b f=%0h, nothing expected", w, fv, se, fval);
      end else if ({se, (fv ? fval : 8'h00)} !== item || (fv && se)) begin
        errors++;
        $display("FAIL out_event inst%0d: got se=%0b fv=%0b f=%0h expected se=%0b f=%0h",
                 w, se, fv, fval, item[8], item[7:0]);
      end
      if (fv) begin
        if (cont[w] && last_fv[w] >= 0) chk($sformatf("cadence_inst%0d", w), cyc - last_fv[w], nn[w]);
        last_fv[w] = cyc;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon(0, fv5, se5, {3'b0, f5});
      mon(1, fv2, se2, {6'b0, f2});
      mon(2, fv8, se8, f8);
    end
  end

  initial begin
    logic [4:0] pat;
    int ph1, ph2;
    for (int w = 0; w < 3; w++) begin
      nv[w] = 0; nd[w] = 0; nf[w] = 0; mbits[w] = '0;
    end
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("rst_f", 32'(f5), 0);
    chk("rst_fvalid", 32'(fv5), 0);
    chk("rst_slot", 32'(sl5), 0);
    chk("rst_locked", 32'(lk5), 0);
    chk("rst_syncerr", 32'(se5), 0);

    // Basic frame 1,0,1,1,0
    pat = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      beat(0, pat[i], i == 0);
      step();
    end
    step();
    chk("t1_fvalid", 32'(fv5), 1);
    chk("t1_f", 32'(f5), 32'h0D);
    chk("t1_locked", 32'(lk5), 1);
    chk("t1_slot", 32'(sl5), 0);
    step();
    chk("t1_fvalid_pulse", 32'(fv5), 0);

    // Same frame with a 3-cycle gap between slots 2 and 3
    for (int i = 0; i < 5; i++) begin
      if (i == 3) repeat (3) step();
      beat(0, pat[i], i == 0);
      step();
    end
    step();
    chk("t2_fvalid", 32'(fv5), 1);
    chk("t2_f", 32'(f5), 32'h0D);
    chk("t2_syncerr", 32'(se5), 0);

    // Restart on beat 3: partial frame dropped, new frame begins on the restart beat
    beat(0, 1, 1); step();
    beat(0, 0, 0); step();
    beat(0, 0, 1); step();
    step();
    chk("t3_syncerr", 32'(se5), 1);
    chk("t3_f_held", 32'(f5), 32'h0D);
    chk("t3_no_fvalid", 32'(fv5), 0);
    chk("t3_slot", 32'(sl5), 1);
    beat(0, 1, 0); step();
    beat(0, 1, 0); step();
    beat(0, 0, 0); step();
    beat(0, 1, 0); step();
    step();
    chk("t3_fvalid", 32'(fv5), 1);
    chk("t3_f_new", 32'(f5), 32'h16);

    // Missing marker at slot 0 drops lock; beats ignored until a marker
    beat(0, 1, 0); step();
    step();
    chk("t4_syncerr", 32'(se5), 1);
    chk("t4_locked", 32'(lk5), 0);
    for (int i = 0; i < 3; i++) begin beat(0, 1, 0); step(); end
    step();
    chk("t4_still_hunt", 32'(lk5), 0);
    pat = 5'b01010;
    for (int i = 0; i < 5; i++) begin beat(0, pat[i], i == 0); step(); end
    step();
    chk("t4_f", 32'(f5), 32'h0A);

    // Asynchronous reset mid-frame after slot 3
    for (int i = 0; i < 4; i++) begin beat(0, 1'b1, i == 0); step(); end
    step();
    #2 reset = 1'b1;
    #1;
    chk("t5_f", 32'(f5), 0);
    chk("t5_fvalid", 32'(fv5), 0);
    chk("t5_slot", 32'(sl5), 0);
    chk("t5_locked", 32'(lk5), 0);
    for (int w = 0; w < 3; w++) pos[w] = -1;
    exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin beat(0, 1'b1, i == 0); step(); end
    step();
    chk("t5_f_ones", 32'(f5), 32'h1F);

    // Continuous back-to-back random frames on N=2 and N=8
    cont[1] = 1; cont[2] = 1;
    ph1 = 0; ph2 = 0;
    for (int c = 0; c < 400; c++) begin
      beat(1, 1'($urandom), ph1 == 0);
      beat(2, 1'($urandom), ph2 == 0);
      ph1 = (ph1 + 1) % 2;
      ph2 = (ph2 + 1) % 8;
      step();
    end
    step();
    cont[1] = 0; cont[2] = 0;
    chk("bb_locked2", 32'(lk2), 1);
    chk("bb_locked8", 32'(lk8), 1);

    // Random gaps and markers on N=5, including framing errors
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(3) != 0) beat(0, 1'($urandom), $urandom_range(7) == 0);
      step();
    end
    repeat (3) step();

    chk("drain_q0", exp_q0.size(), 0);
    chk("drain_q1", exp_q1.size(), 0);
    chk("drain_q2", exp_q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
